emu_reg_bank: RTL and testbench
===============================

# emu_reg_bank

Parametrised bank of emulated asynchronous registers, all evaluated in the single `clock` domain. Each of CHANNELS channels holds a WIDTH-bit value written on a selectable edge of its own slow write-clock input, with per-bit level set/clear overrides. Used wherever the emulated chipset contains clusters of set/reset flops clocked by internally generated strobes; supersedes the single-bit emulated register with width, channel count, edge mode, input synchronisation and true-flop set/clear priority.

## Interface
- `WIDTH`, 8, bits per channel (1..32)
- `CHANNELS`, 4, independent write-clock channels (1..16)
- `EDGE`, 0, capture edge of `wclk`: 0 rising, 1 falling, 2 both
- `SYNC_STAGES`, 0, extra sampling flops on each `wclk` before edge detection (0..3)
- `RESET_VALUE`, 0, WIDTH-bit value loaded into every channel on reset
- `BLOCK_ON_ASYNC`, 1, 1: capture is discarded for bits whose set/clear is active (true flop); 0: bit stores `d` and shows it once override drops
- `clock`  in  1  system clock; all state updates on its falling edge
- `reset`  in  1  asynchronous, active-high reset
- `wclk`  in  CHANNELS  per-channel emulated write clock
- `d`  in  CHANNELS*WIDTH  write data, channel n at [n*WIDTH +: WIDTH]
- `set`  in  CHANNELS*WIDTH  per-bit level set
- `clr`  in  CHANNELS*WIDTH  per-bit level clear, dominates `set`
- `q`  out  CHANNELS*WIDTH  current register values
- `cap`  out  CHANNELS  one-`clock` pulse per accepted capture

## Operation
- Per channel: optional SYNC_STAGES-deep shift of `wclk`, one history flop `wclk_d`, stored value `val[WIDTH]`, `armed` flag, `cap` flop.
- Edge detect at each falling `clock` edge: rise = ~wclk_d & ws, fall = wclk_d & ~ws (ws = synchronised sample); `hit` per EDGE mode; `hit` is forced 0 while `armed`=0.
- Per bit, priority: `reset` -> RESET_VALUE; `clr` -> 0; `set` -> 1; else `val`. `q` is this combinational result.
- Update of `val` per bit at falling `clock` edge: if `hit` and (BLOCK_ON_ASYNC=0 or neither set/clr active) -> `d`; otherwise -> `q` (override levels are absorbed, so a released set leaves 1, a released clear leaves 0).
- `cap[n]` <= `hit[n]`; high even if every bit of the channel was blocked.
- Channels fully independent; simultaneous edges on several channels all capture in the same cycle.

## Timing
- Reset (async, immediate): `val`=RESET_VALUE, sync/history flops=0, `armed`=0, `cap`=0; `q`=RESET_VALUE while `reset` high regardless of set/clr.
- First falling `clock` edge after reset release: loads history, sets `armed`, no capture (no spurious edge from `wclk` already high).
- Latency `wclk` transition to `val`: captured at the (SYNC_STAGES+1)th falling `clock` edge after the transition; `d` is sampled at that same edge. `q` changes combinationally right after it; `cap` high for the following full clock period.
- `set`/`clr` affect `q` combinationally, zero latency; absorbed into `val` at next falling edge.
- `wclk` pulse high or low narrower than one `clock` period may be lost; both-edge mode needs each level held >=1 period. No overrun detection.
- Reset asserted mid-capture: capture lost, re-arm sequence applies.

## Test plan
- Reset, RESET_VALUE=8'hA5, `wclk[0]` held 1 through release -> `q` ch0 = 8'hA5 after 3 clocks, no `cap`.
- EDGE=0, SYNC_STAGES=0, `d` ch1=8'h3C, raise `wclk[1]` -> ch1 `q`=8'h3C after first falling edge, `cap[1]` one period; falling `wclk` no capture.
- EDGE=2, SYNC_STAGES=2: toggle `wclk[2]` with d=8'h11 then 8'h22 -> each captured 3 falling edges after its transition, two `cap` pulses.
- BLOCK_ON_ASYNC=1, ch0 `set`=8'h01, capture d=8'h00, release set -> `q`=8'h01 (bit0 blocked); BLOCK_ON_ASYNC=0 same -> `q`=8'h00.
- `set` and `clr` both high on bit 7 -> `q` bit 7 = 0; release both -> stays 0.
- Simultaneous rising edges on all 4 channels with distinct data 8'h10..8'h13 -> all captured same cycle, `cap`=4'hF.

Source files
------------

// File: rtl/emu_reg_bank.sv
// -----------------------------------------------------------------------------
// emu_reg_bank
// Bank of CHANNELS emulated asynchronous registers, WIDTH bits each. Every
// channel captures its slice of d on a selectable edge of its own slow write
// clock (wclk), detected by sampling in the system clock domain. Per-bit level
// set/clear overrides act on q immediately and are absorbed into the stored
// value at the next falling clock edge. All state updates on negedge clock.
//
// Ports:
//   clock  - system clock, state updates on its falling edge
//   reset  - asynchronous, active-high; forces q to RESET_VALUE
//   wclk   - per-channel emulated write clock
//   d      - write data, channel n at [n*WIDTH +: WIDTH]
//   set    - per-bit level set
//   clr    - per-bit level clear, dominates set
//   q      - current register values (combinational over stored value)
//   cap    - one-clock pulse per accepted capture, per channel
// -----------------------------------------------------------------------------
module emu_reg_bank #(
    parameter int unsigned      WIDTH          = 8,
    parameter int unsigned      CHANNELS       = 4,
    parameter int unsigned      EDGE           = 0,   // 0 rising, 1 falling, 2 both
    parameter int unsigned      SYNC_STAGES    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter bit               BLOCK_ON_ASYNC = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       wclk,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS*WIDTH-1:0] set,
    input  logic [CHANNELS*WIDTH-1:0] clr,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       cap
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0] d_n, set_n, clr_n, q_n, blk_n;
        logic [WIDTH-1:0] val_q, val_d;
        logic             wclk_d_q, wclk_d_d;
        logic             armed_q, armed_d;
        logic             cap_q, cap_d;
        logic             ws, rise, fall, hit;

        assign d_n   = d[n*WIDTH +: WIDTH];
        assign set_n = set[n*WIDTH +: WIDTH];
        assign clr_n = clr[n*WIDTH +: WIDTH];

        // Optional sampling chain ahead of edge detection.
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ws = wclk[n];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            always_comb begin
                sync_d[0] = wclk[n];
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(negedge clock or posedge reset) begin
                if (reset) sync_q <= '0;
                else       sync_q <= sync_d;
            end

            assign ws = sync_q[SYNC_STAGES-1];
        end

        // NOTE: every comb output gets a default first so no latch is inferred.
        always_comb begin
            rise = ~wclk_d_q & ws;
            fall = wclk_d_q & ~ws;
            hit  = 1'b0;
            if (EDGE == 0)      hit = rise;
            else if (EDGE == 1) hit = fall;
            else                hit = rise | fall;
            // The first edge after reset only loads history; a wclk already
            // high at release must not look like a rising edge.
            hit = hit & armed_q;

            // Priority: reset, clear, set, stored value.
            if (reset) q_n = RESET_VALUE;
            else       q_n = (val_q | set_n) & ~clr_n;

            // Bits with an active override refuse the capture in true-flop mode.
            blk_n = BLOCK_ON_ASYNC ? (set_n | clr_n) : '0;

            // Non-captured bits reload q, so override levels are absorbed.
            if (hit) val_d = (d_n & ~blk_n) | (q_n & blk_n);
            else     val_d = q_n;

            wclk_d_d = ws;
            armed_d  = 1'b1;
            cap_d    = hit;
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(negedge clock or posedge reset) begin
            if (reset) begin
                val_q    <= RESET_VALUE;
                wclk_d_q <= 1'b0;
                armed_q  <= 1'b0;
                cap_q    <= 1'b0;
            end else begin
                val_q    <= val_d;
                wclk_d_q <= wclk_d_d;
                armed_q  <= armed_d;
                cap_q    <= cap_d;
            end
        end

        assign q[n*WIDTH +: WIDTH] = q_n;
        assign cap[n]              = cap_q;
    end

endmodule

// File: tb/tb_emu_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_emu_reg_bank
// Two instances share clock/reset:
//   dut_a : EDGE=0, SYNC_STAGES=0, RESET_VALUE=8'hA5, BLOCK_ON_ASYNC=1
//   dut_b : EDGE=2, SYNC_STAGES=2, RESET_VALUE=8'h00, BLOCK_ON_ASYNC=0
// Stimulus pushes expected captures (channel, value, capture edge index) into
// a per-instance queue; monitors pop and compare whenever cap is high.
// -----------------------------------------------------------------------------
module tb_emu_reg_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  wclk_a, wclk_b, cap_a, cap_b;
    logic [31:0] d_a, set_a, clr_a, q_a;
    logic [31:0] d_b, set_b, clr_b, q_b;

    typedef struct {
        int         ch;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a, e_b;

    int cyc    = 0;   // falling clock edges seen so far
    int errors = 0;
    int checks = 0;

    emu_reg_bank #(
        .WIDTH(8), .CHANNELS(4), .EDGE(0), .SYNC_STAGES(0),
        .RESET_VALUE(8'hA5), .BLOCK_ON_ASYNC(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .wclk(wclk_a), .d(d_a),
        .set(set_a), .clr(clr_a), .q(q_a), .cap(cap_a)
    );

    emu_reg_bank #(
        .WIDTH(8), .CHANNELS(4), .EDGE(2), .SYNC_STAGES(2),
        .RESET_VALUE(8'h00), .BLOCK_ON_ASYNC(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .wclk(wclk_b), .d(d_b),
        .set(set_b), .clr(clr_b), .q(q_b), .cap(cap_b)
    );

    always #5 clock = ~clock;

    always @(negedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to n rising edges later, then 1 ns past, away from the falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitors sample at the rising edge, half a period after state updates.
    always @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                if (cap_a[c]) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected_cap ch%0d: got cap=1 expected cap=0 at edge %0d", c, cyc);
                    end else begin
                        e_a = qa.pop_front();
                        check($sformatf("a_cap_ch%0d", c), c, e_a.ch);
                        check($sformatf("a_cap_q%0d", c), {24'h0, q_a[c*8 +: 8]}, {24'h0, e_a.val});
                        check($sformatf("a_cap_edge%0d", c), cyc, e_a.cyc);
                    end
                end
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < 4; c++) begin
                if (cap_b[c]) begin
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected_cap ch%0d: got cap=1 expected cap=0 at edge %0d", c, cyc);
                    end else begin
                        e_b = qb.pop_front();
                        check($sformatf("b_cap_ch%0d", c), c, e_b.ch);
                        check($sformatf("b_cap_q%0d", c), {24'h0, q_b[c*8 +: 8]}, {24'h0, e_b.val});
                        check($sformatf("b_cap_edge%0d", c), cyc, e_b.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        wclk_a = 4'b0001;
        wclk_b = 4'b0000;
        d_a = '0; set_a = '0; clr_a = '0;
        d_b = '0; set_b = '0; clr_b = '0;
        set_a[7:0] = 8'hFF;

        // Reset dominates set; q follows RESET_VALUE.
        #2;
        check("rst_q_a",   q_a, 32'hA5A5_A5A5);
        check("rst_q_b",   q_b, 32'h0);
        check("rst_cap_a", {28'h0, cap_a}, 32'h0);
        step(2);
        set_a  = '0;
        reset  = 1'b0;

        // wclk_a[0] held high through release: no capture, value kept.
        step(3);
        check("rel_q_a",   q_a, 32'hA5A5_A5A5);
        check("rel_cap_a", {28'h0, cap_a}, 32'h0);

        // Rising edge capture on dut_a ch1, no capture on the falling edge.
        d_a[15:8] = 8'h3C;
        wclk_a[1] = 1'b1;
        qa.push_back('{1, 8'h3C, cyc + 1});
        step(1);
        check("rise_q_a1", {24'h0, q_a[15:8]}, 32'h3C);
        step(1);
        check("cap_pulse_a1", {31'h0, cap_a[1]}, 32'h0);
        wclk_a[1] = 1'b0;
        step(4);
        check("fall_hold_a1", {24'h0, q_a[15:8]}, 32'h3C);

        // Both-edge mode with two sync stages on dut_b ch2.
        d_b[23:16] = 8'h11;
        wclk_b[2]  = 1'b1;
        qb.push_back('{2, 8'h11, cyc + 3});
        step(2);
        check("sync_lat_b2", {24'h0, q_b[23:16]}, 32'h0);
        step(3);
        d_b[23:16] = 8'h22;
        wclk_b[2]  = 1'b0;
        qb.push_back('{2, 8'h22, cyc + 3});
        step(5);
        check("both_q_b2", {24'h0, q_b[23:16]}, 32'h22);

        // dut_a ch0: clear to 0, then capture 0 with bit0 set (blocked).
        wclk_a[0] = 1'b0;
        step(2);
        d_a[7:0]  = 8'h00;
        wclk_a[0] = 1'b1;
        qa.push_back('{0, 8'h00, cyc + 1});
        step(2);
        wclk_a[0] = 1'b0;
        step(2);
        set_a[7:0] = 8'h01;
        #1;
        check("set_zero_lat_a0", {24'h0, q_a[7:0]}, 32'h01);
        step(1);
        wclk_a[0] = 1'b1;
        qa.push_back('{0, 8'h01, cyc + 1});
        step(1);
        set_a[7:0] = 8'h00;
        #1;
        check("blk_bit0_a0", {24'h0, q_a[7:0]}, 32'h01);
        wclk_a[0] = 1'b0;

        // dut_b ch0: same sequence, non-blocking mode keeps d.
        set_b[7:0] = 8'h01;
        step(1);
        d_b[7:0]  = 8'h00;
        wclk_b[0] = 1'b1;
        qb.push_back('{0, 8'h01, cyc + 3});
        step(3);
        set_b[7:0] = 8'h00;
        #1;
        check("noblk_b0", {24'h0, q_b[7:0]}, 32'h00);
        step(2);
        check("noblk_hold_b0", {24'h0, q_b[7:0]}, 32'h00);

        // Clear dominates set on bit7; set alone on bit6; both absorbed.
        set_a[31] = 1'b1;
        clr_a[31] = 1'b1;
        set_a[30] = 1'b1;
        #1;
        check("setclr_q_a3", {24'h0, q_a[31:24]}, 32'h65);
        step(2);
        set_a[31:30] = 2'b00;
        clr_a[31]    = 1'b0;
        #1;
        check("setclr_rel_a3", {24'h0, q_a[31:24]}, 32'h65);

        // Simultaneous rising edges on all four channels of dut_a.
        wclk_a = 4'b0000;
        step(2);
        d_a    = 32'h1312_1110;
        wclk_a = 4'b1111;
        qa.push_back('{0, 8'h10, cyc + 1});
        qa.push_back('{1, 8'h11, cyc + 1});
        qa.push_back('{2, 8'h12, cyc + 1});
        qa.push_back('{3, 8'h13, cyc + 1});
        step(1);
        check("all_cap_a", {28'h0, cap_a}, 32'hF);
        check("all_q_a",   q_a, 32'h1312_1110);
        step(3);

        check("qa_drained", qa.size(), 32'h0);
        check("qb_drained", qb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
